// File: rtl/axil_csr_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Package  : axil_csr_pkg
// Brief    : Shared types and helpers for the AXI-Lite to CSR bridge
// Revision : 1.0 - initial release
// ============================================================================
package axil_csr_pkg;

   // AXI response encodings
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Register-file access status reported alongside each strobe
   typedef enum logic [1:0] {
      AV_NONE  = 2'd0,
      AV_WR    = 2'd1,
      AV_RD    = 2'd2,
      AV_RANGE = 2'd3
   } av_e;

   // Bridge sequencer states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_STB  = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_STB  = 3'd3,
      ST_RD_RESP = 3'd4
   } state_e;

   // Protection faults become SLVERR, an unmapped register becomes DECERR
   function automatic logic [1:0] av_to_resp(input logic [1:0] av);
      logic [1:0] resp;
      case (av_e'(av))
         AV_NONE:  resp = RESP_OKAY;
         AV_RANGE: resp = RESP_DECERR;
         default:  resp = RESP_SLVERR;
      endcase
      return resp;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axil_csr_bridge_if.sv
`default_nettype none
// ============================================================================
// Interface: axil_csr_bridge_if
// Brief    : AXI4-Lite slave-side bundle (AW, W, B, AR, R channels)
// Revision : 1.0 - initial release
// ============================================================================
interface axil_csr_bridge_if #(
   parameter int AXI_AW = 8,
   parameter int REG_DW = 32
);
   logic [AXI_AW-1:0]   s_awaddr;
   logic                s_awvalid;
   logic                s_awready;
   logic [REG_DW-1:0]   s_wdata;
   logic [REG_DW/8-1:0] s_wstrb;
   logic                s_wvalid;
   logic                s_wready;
   logic [1:0]          s_bresp;
   logic                s_bvalid;
   logic                s_bready;
   logic [AXI_AW-1:0]   s_araddr;
   logic                s_arvalid;
   logic                s_arready;
   logic [REG_DW-1:0]   s_rdata;
   logic [1:0]          s_rresp;
   logic                s_rvalid;
   logic                s_rready;

   modport master (
      output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
             s_araddr, s_arvalid, s_rready,
      input  s_awready, s_wready, s_bresp, s_bvalid, s_arready,
             s_rdata, s_rresp, s_rvalid
   );

   modport slave (
      input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
             s_araddr, s_arvalid, s_rready,
      output s_awready, s_wready, s_bresp, s_bvalid, s_arready,
             s_rdata, s_rresp, s_rvalid
   );
endinterface
`default_nettype wire

// File: rtl/axil_csr_bridge_chan_buf.sv
`default_nettype none
// ============================================================================
// Module   : axil_chan_buf
// Brief    : Single-entry valid/ready payload holder for one AXI channel
// Revision : 1.0 - initial release
// ============================================================================
module axil_chan_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             full,
   output logic [WIDTH-1:0] data,
   input  logic             clear
);
   assign in_ready = !full;

   // Capture on handshake; the consumer releases the entry once it is used
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         full <= 1'b0;
         data <= '0;
      end else if (clear) begin
         full <= 1'b0;
      end else if (in_valid && in_ready) begin
         full <= 1'b1;
         data <= in_data;
      end
   end
endmodule
`default_nettype wire

// File: rtl/axil_csr_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axil_csr_bridge
// Brief    : AXI4-Lite slave that sequences a single-port CSR strobe interface
// Revision : 1.0 - initial release
// ============================================================================
module axil_csr_bridge
   import axil_csr_pkg::*;
#(
   parameter int AXI_AW = 8,
   parameter int REG_DW = 32,
   parameter int REG_AW = 4
) (
   input  logic              clk,
   input  logic              arst_n,
   axil_csr_bridge_if.slave  s,
   output logic [REG_AW-1:0] reg_addr,
   output logic [REG_DW-1:0] reg_wdata,
   output logic              reg_write,
   output logic              reg_read,
   input  logic [REG_DW-1:0] reg_rdata,
   input  logic [1:0]        access_violation
);
   localparam int STRB_W = REG_DW / 8;
   localparam int WORD_W = AXI_AW - 2;

   logic                     aw_full, w_full, ar_full;
   logic [WORD_W-1:0]        aw_word, ar_word;
   logic [REG_DW+STRB_W-1:0] w_buf;
   logic [REG_DW-1:0]        w_data;
   logic [STRB_W-1:0]        w_strb;
   logic                     wr_free, rd_free;
   logic                     aw_range_ok, ar_range_ok, strb_full;
   logic                     wr_pend, rd_pend;

   state_e                   state, state_nx;
   logic                     favor_wr, favor_wr_nx;
   logic                     bvalid, bvalid_nx, rvalid, rvalid_nx;
   logic [1:0]               bresp, bresp_nx, rresp, rresp_nx;
   logic [REG_DW-1:0]        rdata, rdata_nx;
   logic                     reg_write_nx, reg_read_nx;
   logic [REG_AW-1:0]        reg_addr_nx;
   logic [REG_DW-1:0]        reg_wdata_nx;

   // Byte-lane bits [1:0] are dropped on capture; only the word address is kept
   axil_chan_buf #(.WIDTH(WORD_W)) u_aw_buf (
      .clk(clk), .arst_n(arst_n),
      .in_valid(s.s_awvalid), .in_ready(s.s_awready), .in_data(s.s_awaddr[AXI_AW-1:2]),
      .full(aw_full), .data(aw_word), .clear(wr_free)
   );

   axil_chan_buf #(.WIDTH(REG_DW+STRB_W)) u_w_buf (
      .clk(clk), .arst_n(arst_n),
      .in_valid(s.s_wvalid), .in_ready(s.s_wready), .in_data({s.s_wstrb, s.s_wdata}),
      .full(w_full), .data(w_buf), .clear(wr_free)
   );

   axil_chan_buf #(.WIDTH(WORD_W)) u_ar_buf (
      .clk(clk), .arst_n(arst_n),
      .in_valid(s.s_arvalid), .in_ready(s.s_arready), .in_data(s.s_araddr[AXI_AW-1:2]),
      .full(ar_full), .data(ar_word), .clear(rd_free)
   );

   assign {w_strb, w_data} = w_buf;
   assign strb_full        = (w_strb == '1);
   assign wr_pend          = aw_full && w_full;
   assign rd_pend          = ar_full;

   // Address bits above the register window must be zero to hit the file
   generate
      if (WORD_W > REG_AW) begin : g_upper
         assign aw_range_ok = (aw_word[WORD_W-1:REG_AW] == '0);
         assign ar_range_ok = (ar_word[WORD_W-1:REG_AW] == '0);
      end else begin : g_no_upper
         assign aw_range_ok = 1'b1;
         assign ar_range_ok = 1'b1;
      end
   endgenerate

   assign s.s_bvalid = bvalid;
   assign s.s_bresp  = bresp;
   assign s.s_rvalid = rvalid;
   assign s.s_rresp  = rresp;
   assign s.s_rdata  = rdata;

   // State, arbitration pointer and all registered outputs
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state     <= ST_IDLE;
         favor_wr  <= 1'b1;
         bvalid    <= 1'b0;
         bresp     <= RESP_OKAY;
         rvalid    <= 1'b0;
         rresp     <= RESP_OKAY;
         rdata     <= '0;
         reg_write <= 1'b0;
         reg_read  <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
      end else begin
         state     <= state_nx;
         favor_wr  <= favor_wr_nx;
         bvalid    <= bvalid_nx;
         bresp     <= bresp_nx;
         rvalid    <= rvalid_nx;
         rresp     <= rresp_nx;
         rdata     <= rdata_nx;
         reg_write <= reg_write_nx;
         reg_read  <= reg_read_nx;
         reg_addr  <= reg_addr_nx;
         reg_wdata <= reg_wdata_nx;
      end
   end

   // Grant, strobe launch and response capture; strobes are set up one
   // cycle ahead so they are clean registered pulses during the STB state
   always_comb begin
      state_nx     = state;
      favor_wr_nx  = favor_wr;
      bvalid_nx    = bvalid;
      bresp_nx     = bresp;
      rvalid_nx    = rvalid;
      rresp_nx     = rresp;
      rdata_nx     = rdata;
      reg_write_nx = 1'b0;
      reg_read_nx  = 1'b0;
      reg_addr_nx  = reg_addr;
      reg_wdata_nx = reg_wdata;
      wr_free      = 1'b0;
      rd_free      = 1'b0;

      case (state)
         ST_IDLE: begin
            if (wr_pend && (!rd_pend || favor_wr)) begin
               state_nx     = ST_WR_STB;
               reg_addr_nx  = aw_word[REG_AW-1:0];
               reg_wdata_nx = w_data;
               reg_write_nx = aw_range_ok && strb_full;
               if (rd_pend) favor_wr_nx = 1'b0;
            end else if (rd_pend) begin
               state_nx    = ST_RD_STB;
               reg_addr_nx = ar_word[REG_AW-1:0];
               reg_read_nx = ar_range_ok;
               if (wr_pend) favor_wr_nx = 1'b1;
            end
         end
         ST_WR_STB: begin
            wr_free   = 1'b1;
            bvalid_nx = 1'b1;
            state_nx  = ST_WR_RESP;
            if (!aw_range_ok)    bresp_nx = RESP_DECERR;
            else if (!strb_full) bresp_nx = RESP_SLVERR;
            else                 bresp_nx = av_to_resp(access_violation);
         end
         ST_WR_RESP: begin
            if (s.s_bready) begin
               bvalid_nx = 1'b0;
               state_nx  = ST_IDLE;
            end
         end
         ST_RD_STB: begin
            rd_free   = 1'b1;
            rvalid_nx = 1'b1;
            state_nx  = ST_RD_RESP;
            if (!ar_range_ok) begin
               rresp_nx = RESP_DECERR;
               rdata_nx = '0;
            end else begin
               rresp_nx = av_to_resp(access_violation);
               rdata_nx = (av_e'(access_violation) == AV_NONE) ? reg_rdata : '0;
            end
         end
         ST_RD_RESP: begin
            if (s.s_rready) begin
               rvalid_nx = 1'b0;
               state_nx  = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end
endmodule
`default_nettype wire

// File: tb/tb_axil_csr_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_csr_bridge
// Brief    : Self-checking bench for axil_csr_bridge with a reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_axil_csr_bridge;
   localparam int AXI_AW = 8;
   localparam int REG_DW = 32;
   localparam int REG_AW = 4;

   typedef struct packed {
      logic        wr;
      logic [3:0]  addr;
      logic [31:0] data;
   } stb_t;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic [3:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic        reg_write;
   logic        reg_read;
   logic [31:0] reg_rdata;
   logic [1:0]  access_violation;
   logic [1:0]  av_cfg = 2'd0;

   logic [31:0] regmem  [16];
   logic [31:0] ref_mem [16];
   logic        mem_ready = 1'b0;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   hs_cyc = 0;
   int   stb_cyc = 0;
   stb_t log_q[$];

   always #5 clk = ~clk;

   axil_csr_bridge_if #(.AXI_AW(AXI_AW), .REG_DW(REG_DW)) bus ();

   axil_csr_bridge #(.AXI_AW(AXI_AW), .REG_DW(REG_DW), .REG_AW(REG_AW)) dut (
      .clk(clk), .arst_n(arst_n), .s(bus),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_write(reg_write), .reg_read(reg_read),
      .reg_rdata(reg_rdata), .access_violation(access_violation)
   );

   // Simple register file: combinational read, write only when no violation
   assign reg_rdata        = regmem[reg_addr];
   assign access_violation = av_cfg;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!mem_ready) begin
         for (int i = 0; i < 16; i++) regmem[i] <= 32'(i) * 32'h0101_0101;
         mem_ready <= 1'b1;
      end else if (reg_write && av_cfg == 2'd0) begin
         regmem[reg_addr] <= reg_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Strobe monitor: records every strobe cycle and checks exclusivity
   always @(negedge clk) begin
      if (reg_write || reg_read) begin
         check("stb_overlap", 32'(reg_write & reg_read), 32'd0);
         log_q.push_back('{wr: reg_write, addr: reg_addr, data: reg_wdata});
         stb_cyc = cyc;
      end
   end

   function automatic logic [1:0] resp_of(input logic [1:0] av);
      return (av == 2'd0) ? 2'b00 : ((av == 2'd3) ? 2'b11 : 2'b10);
   endfunction

   // Raise the requested valids and drop each one after its handshake
   task automatic send(input bit aw, input bit w, input bit ar);
      bit paw, pw, par, haw, hw, har;
      int n;
      paw = aw; pw = w; par = ar; n = 0;
      if (aw) bus.s_awvalid = 1'b1;
      if (w)  bus.s_wvalid  = 1'b1;
      if (ar) bus.s_arvalid = 1'b1;
      while ((paw || pw || par) && n < 64) begin
         @(negedge clk);
         haw = paw && bus.s_awready;
         hw  = pw  && bus.s_wready;
         har = par && bus.s_arready;
         @(posedge clk); #1;
         if (haw) begin paw = 1'b0; bus.s_awvalid = 1'b0; end
         if (hw)  begin pw  = 1'b0; bus.s_wvalid  = 1'b0; end
         if (har) begin par = 1'b0; bus.s_arvalid = 1'b0; end
         if (haw || hw || har) hs_cyc = cyc;
         n++;
      end
      if (paw || pw || par) check("send_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_b(input logic [1:0] exp_resp, input int hold);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.s_bvalid && n < 20) begin @(negedge clk); n++; end
      check("bvalid_seen", 32'(bus.s_bvalid), 32'd1);
      check("b_latency", 32'(cyc - hs_cyc), 32'd2);
      check("bresp", 32'(bus.s_bresp), 32'(exp_resp));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("b_hold_valid", 32'(bus.s_bvalid), 32'd1);
         check("b_hold_resp", 32'(bus.s_bresp), 32'(exp_resp));
      end
      bus.s_bready = 1'b1;
      @(posedge clk); #1;
      bus.s_bready = 1'b0;
      @(negedge clk);
      check("b_drop", 32'(bus.s_bvalid), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic wait_r(input logic [1:0] exp_resp, input logic [31:0] exp_data, input int hold);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.s_rvalid && n < 20) begin @(negedge clk); n++; end
      check("rvalid_seen", 32'(bus.s_rvalid), 32'd1);
      check("r_latency", 32'(cyc - hs_cyc), 32'd2);
      check("rresp", 32'(bus.s_rresp), 32'(exp_resp));
      check("rdata", bus.s_rdata, exp_data);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("r_hold_valid", 32'(bus.s_rvalid), 32'd1);
         check("r_hold_data", bus.s_rdata, exp_data);
      end
      bus.s_rready = 1'b1;
      @(posedge clk); #1;
      bus.s_rready = 1'b0;
      @(negedge clk);
      check("r_drop", 32'(bus.s_rvalid), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] av, input int w_lead, input int hold);
      bit in_range, all_strb, expect_stb;
      logic [1:0] er;
      in_range   = (addr[7:6] == 2'b00);
      all_strb   = (strb == 4'hF);
      expect_stb = in_range && all_strb;
      er = !in_range ? 2'b11 : (!all_strb ? 2'b10 : resp_of(av));
      av_cfg = av;
      log_q.delete();
      bus.s_awaddr = addr; bus.s_wdata = data; bus.s_wstrb = strb;
      if (w_lead > 0) begin
         send(1'b0, 1'b1, 1'b0);
         repeat (w_lead) @(posedge clk);
         #1;
         check("w_alone_no_stb", 32'(log_q.size()), 32'd0);
         send(1'b1, 1'b0, 1'b0);
      end else begin
         send(1'b1, 1'b1, 1'b0);
      end
      wait_b(er, hold);
      check("wr_stb_count", 32'(log_q.size()), expect_stb ? 32'd1 : 32'd0);
      if (expect_stb && log_q.size() == 1) begin
         check("wr_stb_kind", 32'(log_q[0].wr), 32'd1);
         check("wr_stb_addr", 32'(log_q[0].addr), 32'(addr[5:2]));
         check("wr_stb_data", log_q[0].data, data);
         check("wr_stb_cycle", 32'(stb_cyc - hs_cyc), 32'd1);
         if (av == 2'd0) ref_mem[addr[5:2]] = data;
      end
   endtask

   task automatic do_read(input logic [7:0] addr, input logic [1:0] av, input int hold);
      bit in_range;
      logic [1:0]  er;
      logic [31:0] ed;
      in_range = (addr[7:6] == 2'b00);
      er = in_range ? resp_of(av) : 2'b11;
      ed = (in_range && av == 2'd0) ? ref_mem[addr[5:2]] : 32'd0;
      av_cfg = av;
      log_q.delete();
      bus.s_araddr = addr;
      send(1'b0, 1'b0, 1'b1);
      wait_r(er, ed, hold);
      check("rd_stb_count", 32'(log_q.size()), in_range ? 32'd1 : 32'd0);
      if (in_range && log_q.size() == 1) begin
         check("rd_stb_kind", 32'(log_q[0].wr), 32'd0);
         check("rd_stb_addr", 32'(log_q[0].addr), 32'(addr[5:2]));
      end
   endtask

   task automatic check_idle_outputs(input string pfx);
      check({pfx, "_awready"}, 32'(bus.s_awready), 32'd1);
      check({pfx, "_wready"},  32'(bus.s_wready),  32'd1);
      check({pfx, "_arready"}, 32'(bus.s_arready), 32'd1);
      check({pfx, "_bvalid"},  32'(bus.s_bvalid),  32'd0);
      check({pfx, "_rvalid"},  32'(bus.s_rvalid),  32'd0);
      check({pfx, "_reg_write"}, 32'(reg_write), 32'd0);
      check({pfx, "_reg_read"},  32'(reg_read),  32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0]  ra;
      logic [31:0] rd;
      logic [3:0]  rs;
      logic [1:0]  rv;
      int          n;

      for (int i = 0; i < 16; i++) ref_mem[i] = 32'(i) * 32'h0101_0101;
      bus.s_awaddr = '0; bus.s_awvalid = 1'b0; bus.s_wdata = '0; bus.s_wstrb = '0;
      bus.s_wvalid = 1'b0; bus.s_bready = 1'b0; bus.s_araddr = '0;
      bus.s_arvalid = 1'b0; bus.s_rready = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("rst");
      check("rst_bresp", 32'(bus.s_bresp), 32'd0);
      check("rst_rresp", 32'(bus.s_rresp), 32'd0);
      check("rst_rdata", bus.s_rdata, 32'd0);
      check("rst_reg_addr", 32'(reg_addr), 32'd0);
      check("rst_reg_wdata", reg_wdata, 32'd0);
      arst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases
      do_write(8'h08, 32'h0000_00A5, 4'hF, 2'd0, 0, 0);
      do_write(8'h18, 32'hCAFE_F00D, 4'hF, 2'd0, 3, 4);
      do_write(8'h0C, 32'h1234_5678, 4'hF, 2'd0, 0, 0);
      do_read (8'h0C, 2'd0, 0);
      do_read (8'h0C, 2'd2, 1);
      do_read (8'h40, 2'd0, 0);
      do_write(8'h04, 32'h5555_AAAA, 4'b0011, 2'd0, 0, 0);
      do_write(8'h80, 32'h0BAD_0BAD, 4'hF, 2'd0, 0, 0);
      do_write(8'h10, 32'h7777_7777, 4'hF, 2'd1, 0, 0);
      do_write(8'h2C, 32'h0000_0001, 4'hF, 2'd3, 0, 0);
      do_read (8'h08, 2'd0, 2);

      // Reset while a write response is waiting for bready
      av_cfg = 2'd0;
      bus.s_awaddr = 8'h14; bus.s_wdata = 32'hDEAD_BEEF; bus.s_wstrb = 4'hF;
      send(1'b1, 1'b1, 1'b0);
      n = 0;
      @(negedge clk);
      while (!bus.s_bvalid && n < 20) begin @(negedge clk); n++; end
      check("mid_bvalid_before_rst", 32'(bus.s_bvalid), 32'd1);
      ref_mem[5] = 32'hDEAD_BEEF;
      arst_n = 1'b0;
      #1;
      check_idle_outputs("mid_rst");
      check("mid_rst_bresp", 32'(bus.s_bresp), 32'd0);
      repeat (2) @(negedge clk);
      arst_n = 1'b1;
      @(posedge clk); #1;

      // Write and read both pending every time the bridge is idle
      log_q.delete();
      av_cfg = 2'd0;
      bus.s_awaddr = 8'h04; bus.s_wdata = 32'hC0DE_0001; bus.s_wstrb = 4'hF;
      bus.s_araddr = 8'h10;
      bus.s_bready = 1'b1; bus.s_rready = 1'b1;
      bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; bus.s_arvalid = 1'b1;
      repeat (14) @(posedge clk);
      #1;
      send(1'b1, 1'b1, 1'b1);
      repeat (12) @(posedge clk);
      #1;
      bus.s_bready = 1'b0; bus.s_rready = 1'b0;
      ref_mem[1] = 32'hC0DE_0001;
      check("arb_count", 32'(log_q.size() >= 4), 32'd1);
      if (log_q.size() >= 4) begin
         for (int i = 0; i < 4; i++) begin
            check("arb_kind", 32'(log_q[i].wr), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("arb_addr", 32'(log_q[i].addr), (i % 2 == 0) ? 32'd1 : 32'd4);
         end
      end
      @(negedge clk);
      check_idle_outputs("arb_drain");
      @(posedge clk); #1;

      // Normal traffic after the reset and arbitration runs
      do_write(8'h3C, 32'h0F0F_F0F0, 4'hF, 2'd0, 0, 0);
      do_read (8'h3C, 2'd0, 0);
      do_read (8'h04, 2'd0, 0);

      // Randomized traffic against the reference model
      for (int t = 0; t < 40; t++) begin
         ra = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63));
         rd = $urandom;
         rs = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF;
         rv = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
         if ($urandom_range(0, 1) == 0)
            do_write(ra, rd, rs, rv, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
         else
            do_read(ra, rv, int'($urandom_range(0, 2)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
